core_store_buffer: RTL and testbench

CORE_STORE_BUFFER -- requirements
Module: core_store_buffer

---
 rtl/core_store_buffer.sv | 111 +++++++++++
 tb/tb_core_store_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_store_buffer.sv
// Posted-write store buffer between core and system bus: circular FIFO of writes,
// reads gated until the buffer drains, or past non-matching words with `STORE_BUF_BYPASS_EN.
module core_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_rd_req,
  output logic        s_rd_gnt,
  input  logic [3:0]  s_rd_be,
  input  logic [31:0] s_rd_addr,
  output logic [31:0] s_rd_data,
  input  logic        s_wr_req,
  output logic        s_wr_gnt,
  input  logic [3:0]  s_wr_be,
  input  logic [31:0] s_wr_addr,
  input  logic [31:0] s_wr_data,
  output logic        m_rd_req,
  input  logic        m_rd_gnt,
  output logic [3:0]  m_rd_be,
  output logic [31:0] m_rd_addr,
  input  logic [31:0] m_rd_data,
  output logic        m_wr_req,
  input  logic        m_wr_gnt,
  output logic [3:0]  m_wr_be,
  output logic [31:0] m_wr_addr,
  output logic [31:0] m_wr_data,
  output logic        o_empty,
  output logic [4:0]  o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [31:0]   addr_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic rd_cond;
  logic rd_allowed;

  assign full = (count == 5'(DEPTH));
  assign push = s_wr_req & ~full;
  assign pop  = (count != 5'd0) & m_wr_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= s_wr_addr;
      be_q[wr_ptr]   <= s_wr_be;
      data_q[wr_ptr] <= s_wr_data;
    end
  end

`ifdef STORE_BUF_BYPASS_EN
  logic hazard;

  // Word-granular match against every live entry, walking from the head.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((5'(k) < count) && (addr_q[rd_ptr + PW'(k)][31:2] == s_rd_addr[31:2]))
        hazard = 1'b1;
    end
  end

  assign rd_cond = ~hazard;
`else
  assign rd_cond = (count == 5'd0);
`endif

  // rst_n gating keeps the read channel quiet while reset is held.
  assign rd_allowed = rst_n & s_rd_req & ~s_wr_req & rd_cond;

  assign m_rd_req  = rd_allowed;
  assign m_rd_addr = s_rd_addr;
  assign m_rd_be   = s_rd_be;
  assign s_rd_gnt  = m_rd_gnt & rd_allowed;
  assign s_rd_data = m_rd_data;

  assign s_wr_gnt  = ~full;
  assign m_wr_req  = (count != 5'd0);
  assign m_wr_addr = addr_q[rd_ptr];
  assign m_wr_be   = be_q[rd_ptr];
  assign m_wr_data = data_q[rd_ptr];

  assign o_empty = (count == 5'd0);
  assign o_count = count;

endmodule

// File: tb/tb_core_store_buffer.sv
// Scoreboard bench for core_store_buffer: directed scenarios plus random traffic,
// checked against a queue-based model of posted writes and read gating.
module tb_core_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_rd_req, s_rd_gnt;
  logic [3:0]  s_rd_be;
  logic [31:0] s_rd_addr, s_rd_data;
  logic        s_wr_req, s_wr_gnt;
  logic [3:0]  s_wr_be;
  logic [31:0] s_wr_addr, s_wr_data;
  logic        m_rd_req, m_rd_gnt;
  logic [3:0]  m_rd_be;
  logic [31:0] m_rd_addr, m_rd_data;
  logic        m_wr_req, m_wr_gnt;
  logic [3:0]  m_wr_be;
  logic [31:0] m_wr_addr, m_wr_data;
  logic        o_empty;
  logic [4:0]  o_count;

  core_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rd_req(s_rd_req), .s_rd_gnt(s_rd_gnt), .s_rd_be(s_rd_be),
    .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_gnt(s_wr_gnt), .s_wr_be(s_wr_be),
    .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .m_rd_req(m_rd_req), .m_rd_gnt(m_rd_gnt), .m_rd_be(m_rd_be),
    .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_gnt(m_wr_gnt), .m_wr_be(m_wr_be),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .o_empty(o_empty), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected entries in issue order: {addr[31:0], be[3:0], data[31:0]}.
  logic [67:0] model[$];
  logic [31:0] drained[$];
  int          bus_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%h required=0x%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit read_ok_model(input logic [31:0] addr);
`ifdef STORE_BUF_BYPASS_EN
    foreach (model[i]) if (model[i][67:38] == addr[31:2]) return 1'b0;
    return 1'b1;
`else
    return model.size() == 0;
`endif
  endfunction

  // Monitor/scoreboard: samples mid-cycle, compares, then applies the handshakes due at the next edge.
  always @(negedge clk) begin
    int sz;
    bit rd_ok;
    if (!rst_n) begin
      model.delete();
      chk("rst_s_wr_gnt", 32'(s_wr_gnt), 32'd1);
      chk("rst_m_wr_req", 32'(m_wr_req), 32'd0);
      chk("rst_m_rd_req", 32'(m_rd_req), 32'd0);
      chk("rst_s_rd_gnt", 32'(s_rd_gnt), 32'd0);
      chk("rst_o_empty",  32'(o_empty),  32'd1);
      chk("rst_o_count",  32'(o_count),  32'd0);
    end else begin
      sz = model.size();
      chk("o_count",  32'(o_count),  32'(sz));
      chk("o_empty",  32'(o_empty),  32'(sz == 0));
      chk("s_wr_gnt", 32'(s_wr_gnt), 32'(sz < DEPTH));
      chk("m_wr_req", 32'(m_wr_req), 32'(sz != 0));
      if (sz != 0) begin
        chk("head_addr", m_wr_addr, model[0][67:36]);
        chk("head_be",   32'(m_wr_be), 32'(model[0][35:32]));
        chk("head_data", m_wr_data, model[0][31:0]);
      end
      rd_ok = s_rd_req && !s_wr_req && read_ok_model(s_rd_addr);
      chk("m_rd_req",  32'(m_rd_req), 32'(rd_ok));
      chk("s_rd_gnt",  32'(s_rd_gnt), 32'(rd_ok && m_rd_gnt));
      chk("m_rd_addr", m_rd_addr, s_rd_addr);
      chk("m_rd_be",   32'(m_rd_be), 32'(s_rd_be));
      chk("s_rd_data", s_rd_data, m_rd_data);
      if (m_wr_req && m_wr_gnt) bus_wr++;
      if (sz != 0 && m_wr_gnt) begin
        drained.push_back(model[0][31:0]);
        void'(model.pop_front());
      end
      if (s_wr_req && sz < DEPTH) model.push_back({s_wr_addr, s_wr_be, s_wr_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_wr_req = 1'b0; m_wr_gnt = 1'b0; s_rd_req = 1'b0; m_rd_gnt = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    s_wr_req = 1'b0;
    m_wr_gnt = 1'b1;
    while (!o_empty && n < 40) begin tick(); n++; end
    chk("drain_done", 32'(o_empty), 32'd1);
    m_wr_gnt = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d);
    s_wr_req = 1'b1; s_wr_addr = a; s_wr_data = d; s_wr_be = 4'hF;
    tick();
    s_wr_req = 1'b0;
  endtask

  initial begin
    int bw;
    bit acc;
    int n;
    rst_n = 1'b0;
    s_rd_be = 4'hF; s_rd_addr = '0; m_rd_data = '0;
    s_wr_be = '0; s_wr_addr = '0; s_wr_data = '0;
    idle();
    s_rd_req = 1'b1;  // read request while in reset must stay ungranted
    m_rd_gnt = 1'b1;
    repeat (3) tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Fill with m_wr_gnt low; fifth write is refused.
    for (int i = 0; i < 5; i++) begin
      s_wr_req = 1'b1; s_wr_addr = 32'h100 + 32'(4 * i); s_wr_data = 32'(i + 1); s_wr_be = 4'hF;
      if (i == 4) chk("full_gnt", 32'(s_wr_gnt), 32'd0);
      tick();
    end
    chk("fill_count", 32'(o_count), 32'd4);
    // One pop with the write held: refused now, accepted next cycle.
    m_wr_gnt = 1'b1;
    chk("pop_head", m_wr_addr, 32'h100);
    tick();
    m_wr_gnt = 1'b0;
    chk("after_pop_count", 32'(o_count), 32'd3);
    tick();
    s_wr_req = 1'b0;
    chk("refill_count", 32'(o_count), 32'd4);
    drain();

    // Read to a queued word blocks until the entry drains.
    push_one(32'h200, 32'h11);
    s_rd_req = 1'b1; s_rd_addr = 32'h200; m_rd_gnt = 1'b1; m_rd_data = 32'h0;
    repeat (3) begin
      chk("blocked_rd", 32'(s_rd_gnt), 32'd0);
      tick();
    end
    m_wr_gnt = 1'b1;
    tick();
    m_wr_gnt = 1'b0;
    chk("rd_after_drain", 32'(s_rd_gnt), 32'd1);
    tick();
    s_rd_req = 1'b0; m_rd_gnt = 1'b0;
    m_rd_data = 32'hDEADBEEF;
    #1 chk("rd_data", s_rd_data, 32'hDEADBEEF);

    // Read to a different word with a write queued.
    push_one(32'h200, 32'h22);
    s_rd_req = 1'b1; s_rd_addr = 32'h300; m_rd_gnt = 1'b1;
`ifdef STORE_BUF_BYPASS_EN
    chk("bypass_rd", 32'(s_rd_gnt), 32'd1);
`else
    chk("wait_rd", 32'(s_rd_gnt), 32'd0);
`endif
    repeat (2) tick();
    drain();
    chk("rd_when_empty", 32'(s_rd_gnt), 32'd1);
    tick();
    idle();

    // Seven entries through a depth-4 buffer with toggling drain grant.
    drained.delete();
    for (int i = 1; i <= 7; i++) begin
      s_wr_req = 1'b1; s_wr_addr = 32'h400 + 32'(4 * i); s_wr_data = 32'(i); s_wr_be = 4'(i);
      n = 0;
      do begin
        m_wr_gnt = ~m_wr_gnt;
        acc = s_wr_gnt;
        tick();
        n++;
      end while (!acc && n < 20);
      chk("wrap_push_ok", 32'(acc), 32'd1);
    end
    drain();
    chk("wrap_drained_n", 32'(drained.size()), 32'd7);
    for (int i = 0; i < 7 && i < drained.size(); i++) chk("wrap_order", drained[i], 32'(i + 1));

    // Reset while draining discards the queue and stops bus writes.
    for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
    m_wr_gnt = 1'b1;
    tick();
    chk("mid_drain_count", 32'(o_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_now_count", 32'(o_count), 32'd0);
    chk("rst_now_wr_req", 32'(m_wr_req), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    bw = bus_wr;
    repeat (5) tick();
    chk("no_wr_after_rst", 32'(bus_wr), 32'(bw));
    idle();

    // Random traffic over a small address pool so hazards are frequent.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      s_wr_req  = $urandom_range(0, 1);
      s_wr_addr = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      s_wr_be   = 4'($urandom);
      s_wr_data = $urandom;
      m_wr_gnt  = ($urandom_range(0, 2) != 0);
      s_rd_req  = $urandom_range(0, 1);
      s_rd_addr = 32'h200 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
      s_rd_be   = 4'($urandom);
      m_rd_gnt  = $urandom_range(0, 1);
      m_rd_data = $urandom;
      tick();
    end
    rst_n = 1'b1;
    drain();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
